upsample_2x: RTL and testbench



---
 rtl/upsample_2x_pkg.sv | 14 +
 rtl/upsample_line_buf.sv | 28 ++
 rtl/upsample_2x.sv | 177 +++++++++++++++++
 tb/tb_upsample_2x.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_2x_pkg.sv
// Shared definitions for the 2x2 nearest-neighbour unpooling stage.
// Pixel/line defaults match the max-pooling stage so both ends of the pipeline agree.
package upsample_2x_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LINE_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        FILL   = 3'b010,
        REPLAY = 3'b100
    } state_t;

endpackage

// File: rtl/upsample_line_buf.sv
// One-line pixel store with synchronous write and synchronous 1-cycle read.
// rdata holds its value on cycles without a read.
module upsample_line_buf #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              en,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Sized to the full address space so every address is in range.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/upsample_2x.sv
// 2x2 nearest-neighbour unpooling: each pixel is emitted twice, each line twice.
// Handshake: a pixel is taken on any cycle where in_valid and in_ready are both high; the output side has no backpressure.
module upsample_2x
    import upsample_2x_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] sig_layer,
    input  logic              frame_start_in,
    input  logic              line_start_in,
    input  logic              frame_end_in,
    output logic [DATA_W-1:0] up_layer,
    output logic              valid,
    output logic              frame_start_out,
    output logic              line_start_out,
    output logic              frame_end_out,
    output logic [2:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_W - 1);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] col_q, col_n, raddr_q, raddr_n;
    logic              dup_q, dup_n, fe_latch_q, fe_latch_n, last_q, last_n;
    logic [DATA_W-1:0] up_n;
    logic              valid_n, fs_n, ls_n, fe_n, ready_n;
    logic              buf_en, buf_wen;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] rdata;
    logic              accept;
    logic              unused_line_start;

    // Line position comes from col, so the incoming line marker carries no information.
    assign unused_line_start = line_start_in;
    assign accept            = in_valid & in_ready;
    assign state_dbg         = state_q;

    upsample_line_buf #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_line_buf (
        .clk  (clk),
        .en   (buf_en),
        .wen  (buf_wen),
        .addr (buf_addr),
        .wdata(sig_layer),
        .rdata(rdata)
    );

    always_comb begin
        state_n    = state_q;
        col_n      = col_q;
        raddr_n    = raddr_q;
        dup_n      = dup_q;
        fe_latch_n = fe_latch_q;
        last_n     = last_q;
        up_n       = up_layer;
        valid_n    = 1'b0;
        fs_n       = 1'b0;
        ls_n       = 1'b0;
        fe_n       = 1'b0;
        buf_en     = 1'b0;
        buf_wen    = 1'b0;
        buf_addr   = col_q;
        ready_n    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && frame_start_in) begin
                    buf_en     = 1'b1;
                    buf_wen    = 1'b1;
                    buf_addr   = '0;
                    up_n       = sig_layer;
                    valid_n    = 1'b1;
                    dup_n      = 1'b0;
                    fs_n       = 1'b1;
                    ls_n       = 1'b1;
                    col_n      = ADDR_W'(1);
                    last_n     = 1'b0;
                    fe_latch_n = frame_end_in;
                    state_n    = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    buf_en     = 1'b1;
                    buf_wen    = 1'b1;
                    up_n       = sig_layer;
                    valid_n    = 1'b1;
                    dup_n      = 1'b0;
                    ls_n       = (col_q == '0);
                    fe_latch_n = fe_latch_q | frame_end_in;
                    if (col_q == LAST) begin
                        col_n  = '0;
                        last_n = 1'b1;
                    end else begin
                        col_n = col_q + 1'b1;
                    end
                end else if (valid && !dup_q) begin
                    valid_n = 1'b1;
                    dup_n   = 1'b1;
                    if (last_q) begin
                        // Prefetch entry 0 so REPLAY starts without a bubble.
                        state_n  = REPLAY;
                        raddr_n  = '0;
                        buf_en   = 1'b1;
                        buf_addr = '0;
                    end
                end
            end
            REPLAY: begin
                // dup_q is the copy on the output now; the next copy is its inverse.
                up_n    = rdata;
                valid_n = 1'b1;
                dup_n   = ~dup_q;
                ls_n    = (raddr_q == '0) && dup_q;
                if (!dup_q) begin
                    if (raddr_q == LAST) begin
                        fe_n       = fe_latch_q;
                        fe_latch_n = 1'b0;
                        last_n     = 1'b0;
                        col_n      = '0;
                        state_n    = fe_latch_q ? IDLE : FILL;
                    end else begin
                        raddr_n  = raddr_q + 1'b1;
                        buf_en   = 1'b1;
                        buf_addr = raddr_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            IDLE:    ready_n = 1'b1;
            FILL:    ready_n = ~(valid_n & ~dup_n) & ~last_n;
            default: ready_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            col_q           <= '0;
            raddr_q         <= '0;
            dup_q           <= 1'b0;
            fe_latch_q      <= 1'b0;
            last_q          <= 1'b0;
            up_layer        <= '0;
            valid           <= 1'b0;
            frame_start_out <= 1'b0;
            line_start_out  <= 1'b0;
            frame_end_out   <= 1'b0;
            in_ready        <= 1'b0;
        end else begin
            state_q         <= state_n;
            col_q           <= col_n;
            raddr_q         <= raddr_n;
            dup_q           <= dup_n;
            fe_latch_q      <= fe_latch_n;
            last_q          <= last_n;
            up_layer        <= up_n;
            valid           <= valid_n;
            frame_start_out <= fs_n;
            line_start_out  <= ls_n;
            frame_end_out   <= fe_n;
            in_ready        <= ready_n;
        end
    end

endmodule

// File: tb/tb_upsample_2x.sv
// Bench for upsample_2x with LINE_W=4: a frame-level model expands each input frame
// into its expected output stream, and a negedge compare process checks every valid output.
module tb_upsample_2x;

    localparam int DW = 16;
    localparam int LW = 4;
    localparam int AW = 2;
    localparam int OW = DW + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] sig_layer;
    logic          frame_start_in, line_start_in, frame_end_in;
    logic [DW-1:0] up_layer;
    logic          valid, frame_start_out, line_start_out, frame_end_out;
    logic [2:0]    state_dbg;

    logic [OW-1:0]        exp_q[$];
    logic [OW-1:0]        obs[$];
    int                   stamps[$];
    int                   waits[$];
    logic signed [DW-1:0] frame_px[$];
    int                   cyc = 0;
    int                   n_pass = 0;
    int                   n_fail = 0;

    upsample_2x #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sig_layer      (sig_layer),
        .frame_start_in (frame_start_in),
        .line_start_in  (line_start_in),
        .frame_end_in   (frame_end_in),
        .up_layer       (up_layer),
        .valid          (valid),
        .frame_start_out(frame_start_out),
        .line_start_out (line_start_out),
        .frame_end_out  (frame_end_out),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Frame model: each line is emitted as two passes, each pixel twice per pass.
    task automatic model_frame();
        int nl;
        nl = frame_px.size() / LW;
        for (int l = 0; l < nl; l++)
            for (int r = 0; r < 2; r++)
                for (int p = 0; p < LW; p++)
                    for (int c = 0; c < 2; c++) begin
                        logic fs, ls, fe;
                        fs = (l == 0) && (r == 0) && (p == 0) && (c == 0);
                        ls = (p == 0) && (c == 0);
                        fe = (l == nl - 1) && (r == 1) && (p == LW - 1) && (c == 1);
                        exp_q.push_back({fs, ls, fe, frame_px[l*LW+p]});
                    end
    endtask

    // scoreboard / compare
    always @(negedge clk) begin
        if (!rst && valid) begin
            obs.push_back({frame_start_out, line_start_out, frame_end_out, up_layer});
            stamps.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {13'd0, frame_start_out, line_start_out, frame_end_out, up_layer}, 32'd0);
            end else begin
                check("stream", {13'd0, frame_start_out, line_start_out, frame_end_out, up_layer},
                      {13'd0, exp_q.pop_front()});
            end
        end else if (!rst && (frame_start_out || line_start_out || frame_end_out)) begin
            check("marker_without_valid", {29'd0, frame_start_out, line_start_out, frame_end_out}, 32'd0);
        end
    end

    // driver tasks (called at a negedge)
    task automatic send(input logic [DW-1:0] d, input logic fs, input logic fe, input logic ls, output int waited);
        waited         = 0;
        sig_layer      = d;
        frame_start_in = fs;
        frame_end_in   = fe;
        line_start_in  = ls;
        in_valid       = 1'b1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        else @(negedge clk);
        in_valid       = 1'b0;
        frame_start_in = 1'b0;
        frame_end_in   = 1'b0;
        line_start_in  = 1'b0;
    endtask

    task automatic send_frame(input int gap_at);
        int w;
        waits.delete();
        for (int i = 0; i < frame_px.size(); i++) begin
            send(frame_px[i], i == 0, i == frame_px.size() - 1, (i % LW) == 0, w);
            waits.push_back(w);
            if (i == gap_at) repeat (3) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    function automatic int count_bit(input int b);
        int n;
        n = 0;
        foreach (obs[i]) if (obs[i][b]) n++;
        return n;
    endfunction

    task automatic clear_obs();
        obs.delete();
        stamps.delete();
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        sig_layer      = '0;
        frame_start_in = 1'b0;
        line_start_in  = 1'b0;
        frame_end_in   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {13'd0, valid, in_ready, frame_start_out, line_start_out, frame_end_out, up_layer}, 32'd0);
        check("reset_state", {29'd0, state_dbg}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // single 1-line frame, in_valid held high
        clear_obs();
        frame_px = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        model_frame();
        send_frame(-1);
        wait_drain();
        check("t1_count", obs.size(), 32'd16);
        check("t1_out0", {13'd0, obs[0]}, {13'd0, 1'b1, 1'b1, 1'b0, 16'd1});
        check("t1_out8", {13'd0, obs[8]}, {13'd0, 1'b0, 1'b1, 1'b0, 16'd1});
        check("t1_out15", {13'd0, obs[15]}, {13'd0, 1'b0, 1'b0, 1'b1, 16'd4});
        check("t1_contiguous", stamps[15] - stamps[0], 32'd15);
        check("t1_ready_pix2", waits[1], 32'd1);
        check("t1_ready_pix4", waits[3], 32'd1);

        // 2-line frame with signed extremes
        clear_obs();
        frame_px = '{-16'sd5, 16'sd7, -16'sd32768, 16'sd32767, 16'sd10, 16'sd20, 16'sd30, 16'sd40};
        model_frame();
        send_frame(-1);
        wait_drain();
        check("t2_count", obs.size(), 32'd32);
        check("t2_min", {13'd0, obs[5]}, {13'd0, 3'b000, 16'h8000});
        check("t2_max", {13'd0, obs[7]}, {13'd0, 3'b000, 16'h7fff});
        check("t2_out16", {13'd0, obs[16]}, {13'd0, 1'b0, 1'b1, 1'b0, 16'd10});
        check("t2_out24", {13'd0, obs[24]}, {13'd0, 1'b0, 1'b1, 1'b0, 16'd10});
        check("t2_fs_count", count_bit(DW + 2), 32'd1);
        check("t2_fe_count", count_bit(DW), 32'd1);

        // in_valid gap between pixels 2 and 3
        clear_obs();
        frame_px = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        model_frame();
        send_frame(1);
        wait_drain();
        check("t3_count", obs.size(), 32'd16);
        check("t3_span", stamps[15] - stamps[0], 32'd17);
        check("t3_replay_contiguous", stamps[15] - stamps[8], 32'd7);

        // back-to-back frames
        clear_obs();
        frame_px = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
        model_frame();
        send_frame(-1);
        frame_px = '{16'sd11, 16'sd12, 16'sd13, 16'sd14};
        model_frame();
        send_frame(-1);
        check("t4_held_cycles", waits[0], 32'd9);
        wait_drain();
        check("t4_count", obs.size(), 32'd32);
        check("t4_f2_first", {13'd0, obs[16]}, {13'd0, 1'b1, 1'b1, 1'b0, 16'd11});
        check("t4_no_gap", stamps[16] - stamps[15], 32'd1);

        // reset at output index 6
        clear_obs();
        frame_px = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        model_frame();
        send_frame(-1);
        #1;
        check("t5_seen_before_rst", obs.size(), 32'd7);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t5_outputs_zero", {13'd0, valid, in_ready, frame_start_out, line_start_out, frame_end_out, up_layer}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_no_more_valid", obs.size(), 32'd7);
        check("t5_no_frame_end", count_bit(DW), 32'd0);
        clear_obs();
        frame_px = '{16'sd21, 16'sd22, 16'sd23, 16'sd24};
        model_frame();
        send_frame(-1);
        wait_drain();
        check("t5_after_count", obs.size(), 32'd16);
        check("t5_after_last", {13'd0, obs[15]}, {13'd0, 1'b0, 1'b0, 1'b1, 16'd24});

        // pixels without frame_start_in in IDLE are discarded
        clear_obs();
        begin
            int w;
            send(16'd9, 1'b0, 1'b0, 1'b1, w);
            send(16'd9, 1'b0, 1'b0, 1'b0, w);
        end
        repeat (10) @(negedge clk);
        check("t6_discard", obs.size(), 32'd0);
        frame_px = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4};
        model_frame();
        send_frame(-1);
        wait_drain();
        check("t6_count", obs.size(), 32'd16);
        check("t6_out0", {13'd0, obs[0]}, {13'd0, 1'b1, 1'b1, 1'b0, 16'hffff});

        // final report
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
